mac_array_ctrl: RTL and testbench

MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

---
 rtl/mac_ctrl_pkg.sv | 16 +
 rtl/mac_skew_gen.sv | 42 ++++
 rtl/mac_array_ctrl.sv | 118 +++++++++++
 tb/tb_mac_array_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared sizing constants and FSM state encoding for the MAC array controller
package mac_ctrl_pkg;
  localparam int MAC_ROW = 16;
  localparam int MAC_COL = 16;
  localparam int MAX_IFMAP_NUM = 1024;
  localparam int CNT_W = $clog2(MAX_IFMAP_NUM + 1);
  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    W_LOAD,
    IF_START,
    IF_FEED,
    DRAIN,
    DONE
  } state_e;
endpackage

// File: rtl/mac_skew_gen.sv
// mac_skew_gen: per-row ifmap start shift chain with N-cycle read/enable windows
module mac_skew_gen #(
  parameter int ROWS = 16,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             start_in,
  input  logic [CNT_W-1:0] n_in,
  output logic [ROWS-1:0]  rd_en_out,
  output logic [ROWS-1:0]  en_out
);
  logic [ROWS-1:0] sh_q, sh_d, en_q, en_d;
  logic [ROWS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  // start pulse ripples one row per cycle; each row then holds its read strobe for n_in cycles
  always_comb begin
    rd_en_out = '0;
    cnt_d = '0;
    sh_d = clr ? '0 : {sh_q[ROWS-2:0], start_in};
    for (int r = 0; r < ROWS; r++) begin
      rd_en_out[r] = sh_q[r] || (cnt_q[r] != '0);
      cnt_d[r] = clr ? '0 :
                 sh_q[r] ? n_in - CNT_W'(1) :
                 (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
    end
    en_d = clr ? '0 : rd_en_out;
  end
  // skew registers; enable is the read strobe delayed to line up with buffer data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_q <= '0;
      cnt_q <= '0;
      en_q <= '0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      en_q <= en_d;
    end
  end
  assign en_out = en_q;
endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequences weight load, skewed ifmap feed and ofmap completion for a MAC array
module mac_array_ctrl #(
  parameter int MAC_ROW = mac_ctrl_pkg::MAC_ROW,
  parameter int MAC_COL = mac_ctrl_pkg::MAC_COL,
  parameter int MAX_IFMAP_NUM = mac_ctrl_pkg::MAX_IFMAP_NUM,
  parameter int CNT_W = $clog2(MAX_IFMAP_NUM + 1)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start_in,
  input  logic                       abort_in,
  input  logic [CNT_W-1:0]           ifmap_num_in,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       err_out,
  output logic                       w_rd_en_out,
  output logic [$clog2(MAC_ROW)-1:0] w_rd_addr_out,
  output logic                       w_prefetch_out,
  output logic                       w_enable_out,
  output logic [MAC_ROW-1:0]         ifmap_rd_en_out,
  output logic                       ifmap_start_out,
  output logic [MAC_ROW-1:0]         ifmap_enable_out,
  input  logic [MAC_COL-1:0]         ofmap_valid_in
);
  import mac_ctrl_pkg::*;
  localparam int ROW_W = $clog2(MAC_ROW);
  state_e state_q, state_d;
  logic [ROW_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic err_q, err_d, w_en_q, w_en_d, all_cnt;
  logic [MAC_COL-1:0][CNT_W-1:0] col_q, col_d;
  logic [MAC_ROW-1:0] rd_en, en;
  // next state, weight address, job length, column tallies and sticky error
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    n_d = n_q;
    err_d = err_q;
    col_d = col_q;
    all_cnt = 1'b1;
    for (int c = 0; c < MAC_COL; c++) begin
      all_cnt = all_cnt && (col_q[c] == n_q);
      if (state_q != IDLE && ofmap_valid_in[c]) begin
        if (col_q[c] == n_q) err_d = 1'b1;
        else col_d[c] = col_q[c] + CNT_W'(1);
      end
    end
    case (state_q)
      IDLE: if (start_in) begin
        state_d = (ifmap_num_in == '0) ? DONE : PREFETCH;
        n_d = ifmap_num_in;
        err_d = 1'b0;
        col_d = '0;
      end
      PREFETCH: begin
        state_d = W_LOAD;
        wcnt_d = ROW_W'(MAC_ROW - 1);
      end
      W_LOAD: begin
        wcnt_d = wcnt_q - ROW_W'(1);
        if (wcnt_q == '0) state_d = IF_START;
      end
      IF_START: state_d = IF_FEED;
      IF_FEED: if (en[MAC_ROW-1] && !rd_en[MAC_ROW-1]) state_d = DRAIN;
      DRAIN: if (all_cnt) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_in) begin
      state_d = IDLE;
      wcnt_d = '0;
      col_d = '0;
      n_d = n_q;
      err_d = err_q;
    end
    w_en_d = !abort_in && state_q == W_LOAD;
  end
  // controller state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      n_q <= '0;
      err_q <= 1'b0;
      w_en_q <= 1'b0;
      col_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      n_q <= n_d;
      err_q <= err_d;
      w_en_q <= w_en_d;
      col_q <= col_d;
    end
  end
  mac_skew_gen #(
    .ROWS (MAC_ROW),
    .CNT_W(CNT_W)
  ) u_skew (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (abort_in),
    .start_in (state_q == IF_START),
    .n_in     (n_q),
    .rd_en_out(rd_en),
    .en_out   (en)
  );
  assign busy_out = state_q != IDLE;
  assign done_out = state_q == DONE;
  assign err_out = err_q;
  assign w_rd_en_out = state_q == W_LOAD;
  assign w_rd_addr_out = w_rd_en_out ? wcnt_q : '0;
  assign w_prefetch_out = state_q == PREFETCH;
  assign w_enable_out = w_en_q;
  assign ifmap_start_out = state_q == IF_START;
  assign ifmap_rd_en_out = rd_en;
  assign ifmap_enable_out = en;
endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: table-driven job vectors with a done-timing scoreboard plus reset/abort sequences
module tb_mac_array_ctrl;
  localparam int R = 16;
  localparam int C = 16;
  localparam int CW = 11;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic start_in = 1'b0;
  logic abort_in = 1'b0;
  logic [CW-1:0] ifmap_num_in = '0;
  logic [C-1:0] ofmap_valid_in = '0;
  logic busy_out, done_out, err_out, w_rd_en_out, w_prefetch_out, w_enable_out, ifmap_start_out;
  logic [3:0] w_rd_addr_out;
  logic [R-1:0] ifmap_rd_en_out, ifmap_enable_out;
  logic [42:0] got;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int sb[$];
  typedef struct {
    int n;
    int extra;
    bit bstart;
    int ab;
  } vec_t;
  vec_t vecs[8];

  mac_array_ctrl dut (
    .clk(clk), .rstn(rstn), .start_in(start_in), .abort_in(abort_in),
    .ifmap_num_in(ifmap_num_in), .busy_out(busy_out), .done_out(done_out),
    .err_out(err_out), .w_rd_en_out(w_rd_en_out), .w_rd_addr_out(w_rd_addr_out),
    .w_prefetch_out(w_prefetch_out), .w_enable_out(w_enable_out),
    .ifmap_rd_en_out(ifmap_rd_en_out), .ifmap_start_out(ifmap_start_out),
    .ifmap_enable_out(ifmap_enable_out), .ofmap_valid_in(ofmap_valid_in)
  );

  assign got = {busy_out, done_out, err_out, w_rd_en_out, w_rd_addr_out, w_prefetch_out,
                w_enable_out, ifmap_rd_en_out, ifmap_start_out, ifmap_enable_out};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
    compared++;
    if (g !== e) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, g, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected output bundle k cycles after the start edge, from the documented job timeline
  function automatic logic [42:0] expv(int k, int n, bit e, int ab);
    logic [R-1:0] rd, en;
    logic [3:0] addr;
    logic busy, done, wr, pref, wen, ifs;
    int kd;
    kd = (n == 0) ? 1 : 2 * R + n + 4;
    if (ab != 0 && k > ab) return {2'b00, e, 40'b0};
    busy = k >= 1 && k <= kd;
    done = k == kd;
    wr = n > 0 && k >= 2 && k <= R + 1;
    addr = wr ? 4'(R + 1 - k) : 4'd0;
    pref = n > 0 && k == 1;
    wen = n > 0 && k >= 3 && k <= R + 2;
    ifs = n > 0 && k == R + 2;
    rd = '0;
    en = '0;
    for (int r = 0; r < R; r++) begin
      rd[r] = n > 0 && k >= R + 3 + r && k < R + 3 + r + n;
      en[r] = n > 0 && k >= R + 4 + r && k < R + 4 + r + n;
    end
    return {busy, done, e, wr, addr, pref, wen, rd, ifs, en};
  endfunction

  task automatic run_job(input vec_t v);
    int kd, klast;
    bit e;
    kd = (v.n == 0) ? 1 : 2 * R + v.n + 4;
    klast = (v.ab != 0) ? v.ab + 3 : kd + 3;
    start_in = 1'b1;
    ifmap_num_in = CW'(v.n);
    if (v.ab == 0) sb.push_back(cyc + kd);
    step();
    start_in = 1'b0;
    for (int k = 1; k <= klast; k++) begin
      e = v.extra >= 0 && k >= R + 5 + v.n;
      chk($sformatf("job n=%0d k=%0d", v.n, k), 64'(got), 64'(expv(k, v.n, e, v.ab)));
      abort_in = (k == v.ab);
      start_in = v.bstart && (k == 5 || k == R + 8);
      if (start_in) ifmap_num_in = CW'(7);
      ofmap_valid_in = (v.n > 0 && k >= R + 4 && k <= R + 3 + v.n) ? {C{1'b1}} :
                       (v.extra >= 0 && k == R + 4 + v.n) ? C'(1) << v.extra : '0;
      step();
    end
    abort_in = 1'b0;
    start_in = 1'b0;
    ofmap_valid_in = '0;
  endtask

  // every done pulse must match the oldest expected completion cycle
  always @(negedge clk) begin
    if (done_out) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done cyc=%0d got=1 exp=0", cyc);
      end else begin
        chk("done_timing", 64'(cyc), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    vecs[0] = '{10, -1, 1'b0, 0};
    vecs[1] = '{0, -1, 1'b0, 0};
    vecs[2] = '{10, -1, 1'b0, 6};
    vecs[3] = '{4, -1, 1'b0, 0};
    vecs[4] = '{10, 3, 1'b0, 0};
    vecs[5] = '{1, -1, 1'b0, 0};
    vecs[6] = '{10, -1, 1'b1, 0};
    vecs[7] = '{3, -1, 1'b0, 0};
    #1 rstn = 1'b0;
    #1 chk("reset_state", 64'(got), 64'd0);
    step();
    step();
    rstn = 1'b1;
    step();
    chk("idle_after_reset", 64'(got), 64'd0);
    for (int i = 0; i < 8; i++) run_job(vecs[i]);
    start_in = 1'b1;
    ifmap_num_in = CW'(10);
    step();
    start_in = 1'b0;
    repeat (R + 5) step();
    chk("feed_before_reset", 64'(busy_out), 64'd1);
    #2 rstn = 1'b0;
    #1 chk("async_reset", 64'(got), 64'd0);
    step();
    chk("reset_held", 64'(got), 64'd0);
    rstn = 1'b1;
    for (int i = 0; i < 60; i++) step();
    chk("post_reset_idle", 64'(got), 64'd0);
    abort_in = 1'b1;
    start_in = 1'b1;
    ifmap_num_in = CW'(5);
    step();
    abort_in = 1'b0;
    start_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_beats_start %0d", i), 64'(got), 64'd0);
      step();
    end
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
